// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Resolves load-use hazards (one-cycle bubble), multi-cycle EX ops (stall
// until ex_busy drops, with a watchdog) and taken branches/jumps (redirect
// plus FLUSH_EXTRA further IF/ID flush cycles).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_reg1_re/raddr, id_reg2_re/raddr   ID-stage source operands
//   ex_is_load, ex_we, ex_waddr          EX-stage destination info
//   ex_busy                  EX holds a multi-cycle operation
//   ex_jump, ex_jump_addr    taken branch/jump resolved in EX
//   stall_pc, stall_ifid, bubble_idex, bubble_exmem, flush_ifid, flush_idex
//                            pipeline controls (combinational, zero latency)
//   jump_o, jump_addr_o      PC redirect (address is 0 when jump_o is 0)
//   wdt_timeout              sticky: ex_busy lasted WDT_LIMIT cycles
//   stall_cnt                cycles with stall_pc=1 (wraps)
//   flush_cnt                redirects taken (saturates)
module hazard_ctrl #(
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned WDT_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_re,
  input  logic [4:0]  id_reg1_raddr,
  input  logic        id_reg2_re,
  input  logic [4:0]  id_reg2_raddr,
  input  logic        ex_is_load,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_busy,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_addr,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        bubble_idex,
  output logic        bubble_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        wdt_timeout,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned FC_W  = 2;
  localparam int unsigned WDT_W = (WDT_LIMIT < 2) ? 1 : $clog2(WDT_LIMIT + 1);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_EXTRA);
  localparam logic [WDT_W-1:0] WDT_MAX    = WDT_W'(WDT_LIMIT);
  localparam logic             HAS_EXTRA  = (FLUSH_EXTRA > 0);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             load_use;

  // Load in EX writing a register the ID instruction reads; x0 never hazards.
  assign load_use = ex_is_load & ex_we & (ex_waddr != 5'd0) &
                    ((id_reg1_re & (id_reg1_raddr == ex_waddr)) |
                     (id_reg2_re & (id_reg2_raddr == ex_waddr)));

  // Next state and pipeline controls.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    wdt_d        = wdt_q;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    jump_o       = 1'b0;
    jump_addr_o  = 32'd0;

    case (state_q)
      ST_RUN: begin
        if (ex_jump) begin
          jump_o      = 1'b1;
          jump_addr_o = ex_jump_addr;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          fcnt_d      = FLUSH_LOAD;
          state_d     = HAS_EXTRA ? ST_FLUSH : ST_RUN;
        end else if (ex_busy) begin
          // ID/EX holds its instruction; EX/MEM gets a bubble while EX works.
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          bubble_exmem = 1'b1;
          wdt_d        = WDT_W'(1);
          state_d      = ST_MC_WAIT;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end
      end

      ST_MC_WAIT: begin
        if (ex_busy) begin
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          bubble_exmem = 1'b1;
          if (wdt_q < WDT_MAX) wdt_d = wdt_q + WDT_W'(1);
        end else begin
          wdt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_FLUSH: begin
        if (ex_jump) begin
          // A new redirect restarts the flush window.
          jump_o      = 1'b1;
          jump_addr_o = ex_jump_addr;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          fcnt_d      = FLUSH_LOAD;
        end else begin
          flush_ifid = 1'b1;
          fcnt_d     = fcnt_q - FC_W'(1);
          if (fcnt_q <= FC_W'(1)) state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Reset quiets every control regardless of inputs.
    if (rst) begin
      stall_pc     = 1'b0;
      stall_ifid   = 1'b0;
      bubble_idex  = 1'b0;
      bubble_exmem = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      jump_o       = 1'b0;
      jump_addr_o  = 32'd0;
    end
  end

  // State, flush and watchdog counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wdt_q   <= wdt_d;
    end
  end

  // Sticky watchdog flag: set on the edge the busy count reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_timeout <= 1'b0;
    end else if (bubble_exmem && (wdt_d == WDT_MAX)) begin
      wdt_timeout <= 1'b1;
    end
  end

  // Performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_pc) stall_cnt <= stall_cnt + 32'd1;
      if (jump_o && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with fixed expectations plus a
// randomized run checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int FE  = 1;
  localparam int LIM = 8;

  // Control vector order: stall_pc stall_ifid bubble_idex bubble_exmem
  //                       flush_ifid flush_idex jump_o
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1110000;
  localparam logic [6:0] C_MC   = 7'b1101000;
  localparam logic [6:0] C_JMP  = 7'b0000111;
  localparam logic [6:0] C_FL   = 7'b0000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_reg1_re = 1'b0, id_reg2_re = 1'b0;
  logic [4:0]  id_reg1_raddr = '0, id_reg2_raddr = '0, ex_waddr = '0;
  logic        ex_is_load = 1'b0, ex_we = 1'b0, ex_busy = 1'b0, ex_jump = 1'b0;
  logic [31:0] ex_jump_addr = '0;
  logic        stall_pc, stall_ifid, bubble_idex, bubble_exmem, flush_ifid, flush_idex;
  logic        jump_o, wdt_timeout;
  logic [31:0] jump_addr_o, stall_cnt;
  logic [15:0] flush_cnt;
  logic [6:0]  ctl;

  int checks   = 0;
  int failures = 0;

  // Model state
  int          m_flush_left, m_busy_len, m_stall_cnt, m_flush_cnt;
  bit          m_in_mc, m_to;
  logic [6:0]  exp_ctl;
  logic [31:0] exp_addr;

  hazard_ctrl #(.FLUSH_EXTRA(FE), .WDT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_re(id_reg1_re), .id_reg1_raddr(id_reg1_raddr),
    .id_reg2_re(id_reg2_re), .id_reg2_raddr(id_reg2_raddr),
    .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_busy(ex_busy), .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .wdt_timeout(wdt_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {stall_pc, stall_ifid, bubble_idex, bubble_exmem, flush_ifid, flush_idex, jump_o};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_reg1_re = 0; id_reg2_re = 0; id_reg1_raddr = 0; id_reg2_raddr = 0;
    ex_is_load = 0; ex_we = 0; ex_waddr = 0; ex_busy = 0; ex_jump = 0; ex_jump_addr = 0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_is_load = 1; ex_we = 1; ex_waddr = r; id_reg2_re = 1; id_reg2_raddr = r;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    m_flush_left = 0; m_busy_len = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    m_in_mc = 0; m_to = 0;
  endtask

  task automatic model_eval();
    bit lu;
    lu = ex_is_load && ex_we && (ex_waddr != 0) &&
         ((id_reg1_re && id_reg1_raddr == ex_waddr) || (id_reg2_re && id_reg2_raddr == ex_waddr));
    exp_ctl  = C_NONE;
    exp_addr = 32'd0;
    if (rst) return;
    if (m_flush_left > 0) begin
      if (ex_jump) begin exp_ctl = C_JMP; exp_addr = ex_jump_addr; end
      else exp_ctl = C_FL;
    end else if (m_in_mc) begin
      if (ex_busy) exp_ctl = C_MC;
    end else if (ex_jump) begin
      exp_ctl = C_JMP; exp_addr = ex_jump_addr;
    end else if (ex_busy) begin
      exp_ctl = C_MC;
    end else if (lu) begin
      exp_ctl = C_LU;
    end
  endtask

  task automatic model_clock();
    if (m_flush_left > 0) begin
      if (ex_jump) m_flush_left = FE; else m_flush_left--;
    end else if (m_in_mc) begin
      if (ex_busy) begin if (m_busy_len < LIM) m_busy_len++; end
      else begin m_in_mc = 0; m_busy_len = 0; end
    end else if (ex_jump) begin
      m_flush_left = FE;
    end else if (ex_busy) begin
      m_in_mc = 1; m_busy_len = 1;
    end
    if (exp_ctl == C_MC && m_busy_len == LIM) m_to = 1;
    if (exp_ctl[6]) m_stall_cnt++;
    if (exp_ctl[0] && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_load_use(5'd7); ex_jump = 1; ex_busy = 1; ex_jump_addr = 32'hCAFE_0000;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
    checks++;
    if (jump_addr_o !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", jump_addr_o); end
    checks++;
    if ({wdt_timeout, stall_cnt, flush_cnt} !== 49'd0)
      begin failures++; $display("FAIL reset_status wdt=%b stall=%0d flush=%0d exp=0", wdt_timeout, stall_cnt, flush_cnt); end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5);
    #1;
    checks++;
    if (ctl !== C_LU) begin failures++; $display("FAIL lu_cycle0 got=%b exp=%b", ctl, C_LU); end
    tick();
    ex_is_load = 0; ex_we = 0; ex_waddr = 0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lu_cycle1 got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_x0_exempt();
    apply_reset();
    set_load_use(5'd0);
    id_reg1_re = 1; id_reg1_raddr = 0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL x0_ctl got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL x0_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_jump();
    apply_reset();
    ex_jump = 1; ex_jump_addr = 32'h0000_0100;
    #1;
    checks++;
    if (ctl !== C_JMP || jump_addr_o !== 32'h100)
      begin failures++; $display("FAIL jump_c0 got=%b/%h exp=%b/00000100", ctl, jump_addr_o, C_JMP); end
    tick();
    ex_jump = 0; ex_jump_addr = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (ctl !== C_FL || jump_addr_o !== 32'd0)
      begin failures++; $display("FAIL jump_c1 got=%b/%h exp=%b/0", ctl, jump_addr_o, C_FL); end
    tick();
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL jump_c2 got=%b exp=%b", ctl, C_NONE); end
    checks++;
    if (flush_cnt !== 16'd1) begin failures++; $display("FAIL jump_flush_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_jump_vs_load_use();
    apply_reset();
    set_load_use(5'd9);
    ex_jump = 1; ex_jump_addr = 32'h0000_2000;
    #1;
    checks++;
    if (ctl !== C_JMP || jump_addr_o !== 32'h2000)
      begin failures++; $display("FAIL jump_vs_lu got=%b/%h exp=%b/00002000", ctl, jump_addr_o, C_JMP); end
    tick();
    // Load-use ignored inside the flush window.
    ex_jump = 0;
    #1;
    checks++;
    if (ctl !== C_FL) begin failures++; $display("FAIL flush_ignores_lu got=%b exp=%b", ctl, C_FL); end
    tick();
    clear_inputs();
  endtask

  task automatic test_multicycle();
    apply_reset();
    ex_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== C_MC) begin failures++; $display("FAIL mc_busy%0d got=%b exp=%b", i, ctl, C_MC); end
      tick();
    end
    ex_busy = 0;
    ex_jump = 1;  // jump ignored while the multi-cycle op finishes
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL mc_release got=%b exp=%b", ctl, C_NONE); end
    tick();
    ex_jump = 0;
    checks++;
    if (stall_cnt !== 32'd4 || wdt_timeout !== 1'b0)
      begin failures++; $display("FAIL mc_status stall=%0d wdt=%b exp=4/0", stall_cnt, wdt_timeout); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    ex_busy = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (wdt_timeout !== (i >= LIM))
        begin failures++; $display("FAIL wdt_edge%0d got=%b exp=%b", i, wdt_timeout, (i >= LIM)); end
    end
    ex_busy = 0;
    tick(); tick();
    checks++;
    if (wdt_timeout !== 1'b1) begin failures++; $display("FAIL wdt_sticky got=%b exp=1", wdt_timeout); end
    rst = 1'b1;
    #1;
    checks++;
    if (wdt_timeout !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 16'd0)
      begin failures++; $display("FAIL wdt_rst wdt=%b stall=%0d flush=%0d exp=0", wdt_timeout, stall_cnt, flush_cnt); end
    tick();
    rst = 1'b0;
    set_load_use(5'd3);
    #1;
    checks++;
    if (ctl !== C_LU) begin failures++; $display("FAIL wdt_rst_run got=%b exp=%b", ctl, C_LU); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    // Reset in the flush window.
    apply_reset();
    ex_jump = 1; ex_jump_addr = 32'h40;
    tick();
    ex_jump = 0;
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL rst_flush_ctl got=%b exp=%b", ctl, C_NONE); end
    tick();
    rst = 1'b0;
    set_load_use(5'd4);
    #1;
    checks++;
    if (ctl !== C_LU) begin failures++; $display("FAIL rst_flush_run got=%b exp=%b", ctl, C_LU); end
    tick();
    // Reset during a multi-cycle wait.
    apply_reset();
    ex_busy = 1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL rst_mc_ctl got=%b exp=%b", ctl, C_NONE); end
    tick();
    rst = 1'b0;
    ex_busy = 0;
    set_load_use(5'd6);
    #1;
    checks++;
    if (ctl !== C_LU) begin failures++; $display("FAIL rst_mc_run got=%b exp=%b", ctl, C_LU); end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99) < 2);
      id_reg1_re    = $urandom_range(1);
      id_reg2_re    = $urandom_range(1);
      id_reg1_raddr = 5'($urandom_range(3));
      id_reg2_raddr = 5'($urandom_range(3));
      ex_is_load    = $urandom_range(1);
      ex_we         = ($urandom_range(3) != 0);
      ex_waddr      = 5'($urandom_range(3));
      ex_busy       = ($urandom_range(99) < 30);
      ex_jump       = ($urandom_range(99) < 12);
      ex_jump_addr  = $urandom;
      if (rst) model_reset();
      #1;
      model_eval();
      checks++;
      if (ctl !== exp_ctl || jump_addr_o !== exp_addr)
        begin failures++; $display("FAIL rand_ctl i=%0d got=%b/%h exp=%b/%h", i, ctl, jump_addr_o, exp_ctl, exp_addr); end
      @(posedge clk);
      if (!rst) model_clock();
      #1;
      checks++;
      if (stall_cnt !== 32'(m_stall_cnt) || flush_cnt !== 16'(m_flush_cnt) || wdt_timeout !== m_to)
        begin
          failures++;
          $display("FAIL rand_status i=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i,
                   stall_cnt, flush_cnt, wdt_timeout, m_stall_cnt, m_flush_cnt, m_to);
        end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_exempt();
    test_jump();
    test_jump_vs_load_use();
    test_multicycle();
    test_watchdog();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  reset, `RstEnable` = 1.
REQ-002 SHALL take parameter FLUSH_EXTRA, default 1, range 0..3: extra IF/ID flush cycles after a redirect.
REQ-003 SHALL take parameter WDT_LIMIT, default 255: maximum consecutive ex_busy cycles.
REQ-004 SHALL take ID-stage inputs: id_reg1_re in 1, id_reg1_raddr in 5, id_reg2_re in 1, id_reg2_raddr in 5.
REQ-005 SHALL take EX-stage inputs: ex_is_load in 1, ex_we in 1, ex_waddr in 5, ex_busy in 1 (multi-cycle op), ex_jump in 1 (taken branch/jump), ex_jump_addr in 32.
REQ-006 SHALL drive pipeline-control outputs: stall_pc out 1, stall_ifid out 1, bubble_idex out 1, bubble_exmem out 1, flush_ifid out 1, flush_idex out 1.
REQ-007 SHALL drive redirect outputs: jump_o out 1, jump_addr_o out 32.
REQ-008 SHALL drive status outputs: wdt_timeout out 1 (sticky); stall_cnt out 32; flush_cnt out 16.

Function
REQ-009 SHALL implement FSM states RUN, MC_WAIT and FLUSH; all control outputs are combinational from state and current inputs, with zero-cycle latency.
REQ-010 SHALL define load_use = ex_is_load & ex_we & (ex_waddr!=0) & ((id_reg1_re & id_reg1_raddr==ex_waddr) | (id_reg2_re & id_reg2_raddr==ex_waddr)).
REQ-011 SHALL evaluate RUN with priority jump > busy > load_use > none.
REQ-012 SHALL, in RUN with ex_jump=1: drive jump_o=1, jump_addr_o=ex_jump_addr, flush_ifid=1, flush_idex=1; next state is FLUSH if FLUSH_EXTRA>0, else RUN; the flush counter loads FLUSH_EXTRA.
REQ-013 SHALL, in RUN with ex_busy=1: drive stall_pc, stall_ifid, bubble_exmem = 1 and hold the ID/EX contents (bubble_idex=0); next state MC_WAIT; the watchdog counter loads 1.
REQ-014 SHALL, in RUN with load_use=1: drive stall_pc=1, stall_ifid=1, bubble_idex=1 for exactly that cycle; state stays RUN.
REQ-015 SHALL make the forwarded load the only 1-bubble case; the next cycle's re-check sees ex_is_load=0 (bubble) and releases.
REQ-016 SHALL, in MC_WAIT with ex_busy=1: keep the REQ-013 outputs and increment the watchdog counter, saturating at WDT_LIMIT.
REQ-017 SHALL set wdt_timeout=1 when the watchdog counter reaches WDT_LIMIT while ex_busy=1.
REQ-018 SHALL, in MC_WAIT with ex_busy=0: drive all stall outputs 0 and go to RUN that cycle (ex result completes); ex_jump is ignored in MC_WAIT.
REQ-019 SHALL, in FLUSH: drive flush_ifid=1 only and decrement the flush counter; exit to RUN on the cycle the counter reaches 1.
REQ-020 SHALL ignore load_use and ex_busy in FLUSH (IF/ID and EX hold discarded/bubble instructions).
REQ-021 SHALL, on ex_jump=1 in FLUSH, apply the REQ-012 outputs and reload the flush counter (restart).
REQ-022 SHALL drive jump_addr_o=0 whenever jump_o=0.
REQ-023 SHALL make all outputs not named as asserted in a given state/condition 0.
REQ-024 SHALL increment stall_cnt on every clock edge where stall_pc=1, wrapping modulo 2^32.
REQ-025 SHALL increment flush_cnt on every clock edge where jump_o=1, saturating at 0xFFFF.

Reset
REQ-026 SHALL, while rst=1, asynchronously force state=RUN, flush counter=0, watchdog=0, wdt_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-027 SHALL, while rst=1, drive all control outputs 0 and jump_addr_o=0, regardless of inputs.
REQ-028 SHALL, when rst is asserted mid-MC_WAIT or mid-FLUSH, abandon the operation; the first cycle after release is RUN.
REQ-029 SHALL clear wdt_timeout only by rst.

Verification
REQ-030 SHALL cover load-use: ex_is_load=1, ex_we=1, ex_waddr=5, id_reg2_re=1, id_reg2_raddr=5 -> stall_pc=stall_ifid=bubble_idex=1 for one cycle, then 0; stall_cnt=1.
REQ-031 SHALL cover the x0 exemption: same as REQ-030 with ex_waddr=0 and raddr=0 -> no stall.
REQ-032 SHALL cover jump: ex_jump=1, ex_jump_addr=0x0000_0100, FLUSH_EXTRA=1 -> cycle0 jump_o=1, jump_addr_o=0x100, flush_ifid=flush_idex=1; cycle1 flush_ifid=1 only; cycle2 all 0; flush_cnt=1.
REQ-033 SHALL cover jump vs. load_use: ex_jump=1 with load_use true in the same cycle -> REQ-012 outputs only, stall_pc=0.
REQ-034 SHALL cover multi-cycle: ex_busy=1 for 4 cycles, then 0 -> stall_pc=bubble_exmem=1 for 4 cycles, 0 on the 5th; stall_cnt=4; wdt_timeout=0.
REQ-035 SHALL cover watchdog/reset: WDT_LIMIT=8, ex_busy held 10 cycles -> wdt_timeout=1 from the 8th busy cycle and held after ex_busy drops; rst pulse -> wdt_timeout=0, counters 0, state RUN.
